// File: rtl/beat_pkg.sv
// ============================================================================
// Module  : beat_pkg
// Brief   : Shared state encoding and width helpers for the beat detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package beat_pkg;

   typedef enum logic [1:0] {
      WARMUP     = 2'd0,
      ARMED      = 2'd1,
      REFRACTORY = 2'd2
   } bd_state_t;

   function automatic int log2n(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int sum_width(input int w, input int n);
      return w + log2n(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/flux_moving_avg.sv
// ============================================================================
// Module  : flux_moving_avg
// Brief   : N-entry circular history of flux samples with a running-sum average.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flux_moving_avg
   import beat_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] din,
   output logic [W-1:0] avg
);

   localparam int LOG2N = log2n(N);
   localparam int SUM_W = sum_width(W, N);

   logic [W-1:0]     buf_q [N];
   logic [LOG2N-1:0] ptr_q, ptr_d;
   logic [SUM_W-1:0] sum_q, sum_d;

   // avg reflects history before the sample being written this cycle
   always_comb begin
      ptr_d = ptr_q;
      sum_d = sum_q;
      if (wr_en) begin
         sum_d = sum_q + SUM_W'(din) - SUM_W'(buf_q[ptr_q]);
         ptr_d = ptr_q + LOG2N'(1);
      end
      avg = W'(sum_q >> LOG2N);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) buf_q[i] <= '0;
         ptr_q <= '0;
         sum_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         sum_q <= sum_d;
         if (wr_en) buf_q[ptr_q] <= din;
      end
   end

endmodule

`default_nettype wire

// File: rtl/beat_detector.sv
// ============================================================================
// Module  : beat_detector
// Brief   : Adaptive-threshold onset detector with refractory suppression.
//           Define BEAT_DETECTOR_PEAK_EN to also require a non-falling sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module beat_detector
   import beat_pkg::*;
#(
   parameter int W            = 16,
   parameter int N            = 64,
   parameter int REFRACT      = 8,
   parameter int THRESH_SHIFT = 2,
   parameter int MIN_FLUX     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flux_valid,
   input  logic [W-1:0] flux_in,
   output logic         flux_valid_out,
   output logic [W-1:0] flux_out,
   output logic         beat_valid,
   output logic [W-1:0] threshold_out,
   output logic [1:0]   state_out
);

   localparam int LOG2N = log2n(N);
   localparam int RW    = $clog2(REFRACT + 1);
   localparam int TW    = W + 2;

   logic [W-1:0]     avg;
   logic [TW-1:0]    thr_wide;
   logic [W-1:0]     thr;
   logic             peak_ok;
   logic             beat;

   bd_state_t        state_q, state_d;
   logic [LOG2N-1:0] fill_q, fill_d;
   logic [RW-1:0]    refr_q, refr_d;
   logic             fv_q, fv_d;
   logic [W-1:0]     flux_q, flux_d;
   logic             beat_q, beat_d;
   logic [W-1:0]     thr_q, thr_d;

   flux_moving_avg #(
      .W (W),
      .N (N)
   ) u_avg (
      .clk   (clk),
      .reset (reset),
      .wr_en (flux_valid),
      .din   (flux_in),
      .avg   (avg)
   );

   always_comb begin
      thr_wide = TW'(avg) + TW'(avg >> THRESH_SHIFT) + TW'(MIN_FLUX);
      thr      = (|thr_wide[TW-1:W]) ? {W{1'b1}} : thr_wide[W-1:0];
   end

`ifdef BEAT_DETECTOR_PEAK_EN
   logic [W-1:0] prev_q, prev_d;

   always_comb begin
      prev_d  = flux_valid ? flux_in : prev_q;
      peak_ok = (flux_in >= prev_q);
   end

   always_ff @(posedge clk) begin
      if (reset) prev_q <= '0;
      else       prev_q <= prev_d;
   end
`else
   assign peak_ok = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      refr_d  = refr_q;
      beat    = 1'b0;
      case (state_q)
         WARMUP: begin
            if (flux_valid) begin
               if (fill_q == LOG2N'(N - 1)) begin
                  state_d = ARMED;
                  fill_d  = '0;
               end else begin
                  fill_d = fill_q + LOG2N'(1);
               end
            end
         end
         ARMED: begin
            if (flux_valid && (flux_in > thr) && peak_ok) begin
               beat    = 1'b1;
               refr_d  = RW'(REFRACT);
               state_d = REFRACTORY;
            end
         end
         REFRACTORY: begin
            // the sample that drains the counter re-arms but cannot itself fire
            if (flux_valid) begin
               refr_d = refr_q - RW'(1);
               if (refr_q == RW'(1)) state_d = ARMED;
            end
         end
         default: begin
            state_d = WARMUP;
            fill_d  = '0;
            refr_d  = '0;
         end
      endcase

      fv_d   = flux_valid;
      beat_d = beat;
      flux_d = flux_valid ? flux_in : flux_q;
      thr_d  = flux_valid ? thr : thr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WARMUP;
         fill_q  <= '0;
         refr_q  <= '0;
         fv_q    <= 1'b0;
         flux_q  <= '0;
         beat_q  <= 1'b0;
         thr_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         refr_q  <= refr_d;
         fv_q    <= fv_d;
         flux_q  <= flux_d;
         beat_q  <= beat_d;
         thr_q   <= thr_d;
      end
   end

   assign flux_valid_out = fv_q;
   assign flux_out       = flux_q;
   assign beat_valid     = beat_q;
   assign threshold_out  = thr_q;
   assign state_out      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_beat_detector.sv
// ============================================================================
// Module  : tb_beat_detector
// Brief   : Directed and randomized checks of beat_detector against a sample-
//           index reference model. Honours BEAT_DETECTOR_PEAK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_beat_detector;

   localparam int W       = 16;
   localparam int N       = 64;
   localparam int REFRACT = 8;
   localparam int SATMAX  = 65535;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flux_valid = 1'b0;
   logic [W-1:0] flux_in = '0;
   logic         flux_valid_out;
   logic [W-1:0] flux_out;
   logic         beat_valid;
   logic [W-1:0] threshold_out;
   logic [1:0]   state_out;

   int vectors = 0;
   int errors  = 0;

   // reference model: history window, sample index since reset, last beat index
   int hist [N];
   int wp, cnt, last_beat, prev;
   bit have_beat;
   int m_flux, m_thr, m_state;
   bit m_beat;
   bit pat0 [20];
   bit pat7 [20];

   always #5 clk = ~clk;

   beat_detector #(
      .W(W), .N(N), .REFRACT(REFRACT), .THRESH_SHIFT(2), .MIN_FLUX(16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flux_valid     (flux_valid),
      .flux_in        (flux_in),
      .flux_valid_out (flux_valid_out),
      .flux_out       (flux_out),
      .beat_valid     (beat_valid),
      .threshold_out  (threshold_out),
      .state_out      (state_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) hist[i] = 0;
      wp = 0; cnt = 0; last_beat = 0; have_beat = 0; prev = 0;
      m_flux = 0; m_thr = 0; m_state = 0; m_beat = 0;
   endtask

   task automatic check_outs(input string tag, input bit exp_fv);
      chk({tag, ".fv"},    32'(flux_valid_out), 32'(exp_fv));
      chk({tag, ".beat"},  32'(beat_valid),     32'(m_beat && exp_fv));
      chk({tag, ".flux"},  32'(flux_out),       32'(m_flux));
      chk({tag, ".thr"},   32'(threshold_out),  32'(m_thr));
      chk({tag, ".state"}, 32'(state_out),      32'(m_state));
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) begin
         flux_valid = 1'b1;
         flux_in    = W'($urandom);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      flux_valid = 1'b0;
      model_reset();
      check_outs("reset", 1'b0);
   endtask

   task automatic send(input int v);
      longint sum;
      int avg, thr;
      bit elig;
      sum = 0;
      for (int i = 0; i < N; i++) sum += hist[i];
      avg = int'(sum / N);
      thr = avg + avg / 4 + 16;
      if (thr > SATMAX) thr = SATMAX;
      elig = (cnt >= N) && (!have_beat || cnt >= last_beat + REFRACT + 1) && (v > thr);
`ifdef BEAT_DETECTOR_PEAK_EN
      elig = elig && (v >= prev);
`endif
      if (elig) begin
         have_beat = 1;
         last_beat = cnt;
      end
      prev = v;
      hist[wp] = v;
      wp = (wp + 1) % N;
      if (cnt < N - 1) m_state = 0;
      else if (have_beat && cnt < last_beat + REFRACT) m_state = 2;
      else m_state = 1;
      cnt++;
      m_beat = elig;
      m_flux = v;
      m_thr  = thr;

      flux_valid = 1'b1;
      flux_in    = W'(v);
      @(posedge clk);
      #1;
      flux_valid = 1'b0;
      check_outs("sample", 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         check_outs("idle", 1'b0);
      end
   endtask

   function automatic int rnd_flux();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14) return int'($urandom_range(80, 130));
      if (r < 19) return int'($urandom_range(140, 600));
      return int'($urandom_range(0, SATMAX));
   endfunction

   initial begin
      int seq [20];
      // warm-up at 100, then the first armed sample shows threshold 141
      do_reset(2);
      repeat (N - 1) send(100);
      chk("warm.state63", 32'(state_out), 32'd0);
      send(100);
      chk("warm.state64", 32'(state_out), 32'd1);
      send(100);
      chk("warm.thr141", 32'(threshold_out), 32'd141);
      chk("warm.nobeat", 32'(beat_valid), 32'd0);
      send(142);
      chk("beat142", 32'(beat_valid), 32'd1);
      chk("beat142.state", 32'(state_out), 32'd2);

      do_reset(1);
      repeat (N) send(100);
      send(141);
      chk("strict141", 32'(beat_valid), 32'd0);

      // refractory spacing: spikes at k, k+4, k+8, k+9
      do_reset(1);
      repeat (N) send(100);
      for (int i = 0; i <= 9; i++) begin
         send((i == 0 || i == 4 || i == 8 || i == 9) ? 300 : 100);
         if (i == 0) chk("refr.k", 32'(beat_valid), 32'd1);
         if (i == 4) chk("refr.k4", 32'(beat_valid), 32'd0);
         if (i == 8) begin
            chk("refr.k8", 32'(beat_valid), 32'd0);
            chk("refr.k8.state", 32'(state_out), 32'd1);
         end
         if (i == 9) chk("refr.k9", 32'(beat_valid), 32'd1);
      end

      // saturation
      do_reset(1);
      repeat (N) send(SATMAX);
      send(SATMAX);
      chk("sat.thr", 32'(threshold_out), 32'(SATMAX));
      send(0);
      send(SATMAX);
      chk("sat.nobeat", 32'(beat_valid), 32'd0);

      // reset during refractory, then a fresh warm-up
      do_reset(1);
      repeat (N) send(100);
      send(300);
      send(100);
      chk("midrst.pre", 32'(state_out), 32'd2);
      do_reset(1);
      for (int i = 0; i < N; i++) send((i == 10 || i == 30 || i == 63) ? 300 : 100);
      chk("midrst.warmbeat", 32'(beat_valid), 32'd0);
      send(300);
      chk("midrst.firstbeat", 32'(beat_valid), 32'd1);

      // identical beat pattern with back-to-back and 7-cycle strobe spacing
      for (int i = 0; i < 20; i++) seq[i] = rnd_flux();
      do_reset(1);
      repeat (N) send(100);
      for (int i = 0; i < 20; i++) begin
         send(seq[i]);
         pat0[i] = beat_valid;
      end
      do_reset(1);
      repeat (N) begin
         send(100);
         idle(6);
      end
      for (int i = 0; i < 20; i++) begin
         send(seq[i]);
         pat7[i] = beat_valid;
         idle(6);
      end
      for (int i = 0; i < 20; i++) chk("gap.pattern", 32'(pat7[i]), 32'(pat0[i]));

      // falling edge of a broad onset
      do_reset(1);
      repeat (N) send(100);
      repeat (REFRACT + 1) send(300);
      send(290);
`ifdef BEAT_DETECTOR_PEAK_EN
      chk("peak.290", 32'(beat_valid), 32'd0);
`else
      chk("peak.290", 32'(beat_valid), 32'd1);
`endif

      // randomized traffic with random spacing and a random mid-run reset
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         if (i == 350) do_reset(int'($urandom_range(1, 3)));
         send(rnd_flux());
         idle(int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 5)) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
